encoder_level: RTL
==================

# encoder_level

Converts one raw two-phase rotary encoder (pins a/b, asynchronous, bouncing) into a registered WIDTH-bit level that drives one `pwm` channel's `level` input. It synchronises and debounces both pins, then decodes quadrature detents in x1 mode. Each detent adjusts the level by STEP. The RGB mixer instantiates three of these, one per colour, each feeding one `pwm`.

## Interface
- WIDTH, 8: level width; must match the downstream `pwm` WIDTH.
- STEP, 1: level change per detent; 1 ≤ STEP < 2^WIDTH.
- DEBOUNCE, 4: consecutive identical synchronised samples required before a pin's debounced value changes; 1 ≤ DEBOUNCE ≤ 255.
- INIT, 0: level value after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- enc_a  in  1  raw encoder phase A, asynchronous.
- enc_b  in  1  raw encoder phase B, asynchronous.
- level  out  WIDTH  current level, registered; connects to `pwm.level`.
- step_cw  out  1  one-cycle pulse on each clockwise detent.
- step_ccw  out  1  one-cycle pulse on each counter-clockwise detent.
- err  out  1  one-cycle pulse on an illegal quadrature transition.

## Operation
- Synchroniser:
  - Two flops per pin: raw → s1 → s2.
  - Reset value is 0.
- Debouncer, independent per pin:
  - 8-bit stable counter. It is cleared when s2 differs from its previous-cycle value. Otherwise it increments, saturating at 255.
  - deb_x ← s2 on the edge where s2 ≠ deb_x and the counter equals DEBOUNCE−1.
  - Reset: deb_x = 0, counter = 0, previous s2 = 0.
- Decoder:
  - State = {deb_a, deb_b}. prev is a registered copy of that state, reset 00.
  - Clockwise sequence: 00→01→11→10→00. Counter-clockwise is the reverse.
  - Detent rules:
    - 10→00 is a CW detent.
    - 01→00 is a CCW detent.
    - Other single-bit transitions are tracked but cause no level change.
  - Illegal transition: both bits change in the same cycle (00↔11, 01↔10). It pulses err. No level change. prev still updates to the new state.
- Level arithmetic, WIDTH+1-bit intermediate:
  - CW: level + STEP.
  - CCW: level − STEP.
  - Overflow/underflow handling is set by ENCODER_SATURATE_EN (see Configuration).
- step_cw and step_ccw pulse on every detent, including when the level is clamped or wraps.
- Reset mid-rotation discards all partial state. The first detent after reset requires a full legal sequence ending in 00.

## Timing
- Reset values: level = INIT; step_cw, step_ccw, err = 0.
- Latency, from the first rising edge N that samples a new stable raw value:
  - s2 updates at N+1.
  - deb updates at N+DEBOUNCE. With DEBOUNCE = 1, deb updates at N+1.
  - level, step_cw, step_ccw, err all update on the edge after deb changes, i.e. N+DEBOUNCE+1.
- Glitch rejection: a raw pulse shorter than DEBOUNCE cycles, as seen at s2, never changes deb.
- Pin events:
  - Both pins settle in the same cycle: decoded as an illegal transition (err).
  - Pins settle in different cycles: decoded as two legal steps.
- At most one detent per cycle. Pulses are never stretched or queued.
- reset asserted takes priority over any concurrent event. Outputs take reset values on the same edge.

## Configuration
- ENCODER_SATURATE_EN:
  - Defined: level clamps at 2^WIDTH−1 when incrementing and at 0 when decrementing.
  - Undefined: level wraps modulo 2^WIDTH.

## Test plan
- Reset, INIT=0x40:
  - Assert reset 2 cycles with pins toggling → level=0x40 and no pulses throughout reset and for DEBOUNCE+3 cycles after.
- Clockwise rotation, DEBOUNCE=4, pins held ≥8 cycles per phase:
  - Drive 00→01→11→10→00 three times → level 0→3.
  - Exactly 3 step_cw pulses, each 1 cycle, each DEBOUNCE+1 cycles after the raw edge into 00.
- Bounce rejection:
  - Toggle enc_a for 3-cycle pulses 5 times, then settle → no deb change during the bursts.
  - Final transition decoded once.
- Illegal transition:
  - From 00, change both pins in the same cycle to 11 → one err pulse, level unchanged.
  - Continue 11→10→00 → one CW step.
- Saturation, WIDTH=8, STEP=16, level=0xF8:
  - With the macro defined: CW detent → 0xFF; then 17 CCW detents → 0x00, with step_ccw pulsing 17 times.
  - Without the macro: CW detent from 0xF8 → 0x08.
- Reset mid-rotation:
  - Drive 00→01→11, assert reset, release, drive 10→00 → no step, level=INIT.

Source files
------------

// File: rtl/encoder_level.sv
// encoder_level: rotary encoder front end producing a WIDTH-bit level.
// Each raw pin goes through a two-flop synchroniser and a debouncer. The
// debounced pair is then decoded as x1 quadrature, and each detent moves the
// level by STEP. Pulses mark CW and CCW detents and illegal transitions.
// Optional feature: define ENCODER_SATURATE_EN to clamp the level at its
// limits. When it is undefined, the level wraps modulo 2^WIDTH.
module encoder_level #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned INIT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             err
);

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q10 = 2'b10,
    Q11 = 2'b11
  } quad_t;

  localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  logic [1:0] pins;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] deb;

  assign pins = {enc_a, enc_b};

  // Two-flop synchroniser for both raw pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  end

  // The counter is evaluated on the sample that is entering s2 (s1 compared
  // against s2). This lets the debounced value move on the same edge that
  // completes DEBOUNCE identical s2 samples. With DEBOUNCE = 1, it moves
  // together with s2.
  for (genvar g = 0; g < 2; g++) begin : g_pin
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       deb_q;

    // Stable-run length of the s2 stream, saturating at 255.
    always_comb begin
      cnt_nxt = cnt + 8'd1;
      if (cnt == 8'hFF) begin
        cnt_nxt = cnt;
      end
      if (s1[g] != s2[g]) begin
        cnt_nxt = '0;
      end
    end

    // Debounced pin value updates once the run reaches DEBOUNCE samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if ((s1[g] != deb_q) && (cnt_nxt == DEB_LAST)) begin
          deb_q <= s1[g];
        end
      end
    end
  end

  assign deb = {g_pin[1].deb_q, g_pin[0].deb_q};

  quad_t      cur;
  quad_t      prev;
  logic       armed;
  logic [1:0] changed;
  logic       illegal;
  logic       single;
  logic       cw_det;
  logic       ccw_det;
  logic       arm_set;

  // Quadrature transition classification.
  always_comb begin
    cur     = quad_t'(deb);
    changed = deb ^ prev;
    illegal = (changed == 2'b11);
    single  = (changed == 2'b01) || (changed == 2'b10);
    cw_det  = (prev == Q10) && (cur == Q00);
    ccw_det = (prev == Q01) && (cur == Q00);
    // A detent counts only after the decoder has seen a legal departure from
    // 00 or an arrival at 00 since reset. Without this, a rotation interrupted
    // by reset would complete into a spurious detent.
    arm_set = ((prev == Q00) && single) || ((cur == Q00) && (changed != 2'b00));
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  // Next level for each direction, using a one-bit-wider intermediate.
  always_comb begin
    sum  = {1'b0, level} + STEP_EXT;
    diff = {1'b0, level} - STEP_EXT;
`ifdef ENCODER_SATURATE_EN
    inc_val = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
    dec_val = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
    inc_val = sum[WIDTH-1:0];
    dec_val = diff[WIDTH-1:0];
`endif
  end

  // Decoder state, arming flag, registered pulses and the level register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= Q00;
      armed    <= 1'b0;
      level    <= INIT_VAL;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev     <= cur;
      step_cw  <= cw_det && armed;
      step_ccw <= ccw_det && armed;
      err      <= illegal;
      if (arm_set) begin
        armed <= 1'b1;
      end
      if (cw_det && armed) begin
        level <= inc_val;
      end else if (ccw_det && armed) begin
        level <= dec_val;
      end
    end
  end

endmodule
